// File: rtl/morty_pkg.sv
// Shared types and constants for the morty instruction-fetch front end:
// exception codes, the NOP used for trap entries, fetch FSM states and the FIFO entry layout.
package morty_pkg;

  localparam logic [3:0]  EXC_INST_ADDR_MISALIGNED = 4'h0;
  localparam logic [3:0]  EXC_INST_ACCESS_FAULT    = 4'h1;
  localparam logic [31:0] NOP_INSN                 = 32'h0000_0013;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  exc;
    logic        trap;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // A trap entry never carries a real instruction word.
  function automatic fetch_entry_t make_trap(input logic [31:0] pc, input logic [3:0] exc);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = NOP_INSN;
    e.exc  = exc;
    e.trap = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/morty_if_fifo.sv
// Synchronous prefetch FIFO: a push becomes visible at the head one cycle later,
// push and pop may coincide at any fill level, flush empties it in one cycle.
module morty_if_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == CW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem[rd_ptr_reg];
  assign count_o = count_reg;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/morty_if_prefetch.sv
// Instruction-fetch front end: pipelined request/grant bus master feeding a prefetch FIFO,
// with precise redirect/flush and traps carried to ID as FIFO entries.
module morty_if_prefetch
  import morty_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        ibus_err_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instruction_o,
  output logic [3:0]  id_exception_o,
  output logic [31:0] id_exc_data_o,
  output logic        id_trap_valid_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_e   state_reg;
  logic [31:0]    fetch_pc_reg;
  logic [31:0]    resp_pc_reg;
  logic [OW-1:0]  outstanding_reg;
  logic [OW-1:0]  outstanding_next;
  logic [OW-1:0]  discard_reg;
  logic           trap_pending_reg;

  logic           issue;
  logic           accept_rsp;
  logic           push;
  logic           pop;
  logic           misaligned;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  fetch_entry_t   push_entry;
  fetch_entry_t   head_entry;
  logic [ENTRY_W-1:0] head_bits;

  assign misaligned = (redirect_pc_i[1:0] != 2'b00);

  // Credit rule: only request when every in-flight response already owns a FIFO slot.
  always_comb begin
    ibus_req_o = 1'b0;
    if (rst_ni && !redirect_valid_i && (state_reg == FETCH_RUN) && !fifo_full
        && (32'(outstanding_reg) < MAX_OUTSTANDING)
        && ((32'(fifo_count) + 32'(outstanding_reg)) < DEPTH)) begin
      ibus_req_o = 1'b1;
    end
  end

  assign ibus_addr_o      = fetch_pc_reg;
  assign issue            = ibus_req_o & ibus_gnt_i;
  // Outstanding counts every unanswered grant, including ones already marked for discard.
  assign outstanding_next = outstanding_reg + OW'(issue) - OW'(ibus_rvalid_i);
  assign accept_rsp       = ibus_rvalid_i && (discard_reg == '0)
                            && (state_reg == FETCH_RUN) && !redirect_valid_i;
  assign push             = !redirect_valid_i && (trap_pending_reg || accept_rsp);
  assign pop              = id_ready_i && !redirect_valid_i;

  always_comb begin
    push_entry.pc   = resp_pc_reg;
    push_entry.inst = ibus_rdata_i;
    push_entry.exc  = '0;
    push_entry.trap = 1'b0;
    if (trap_pending_reg) begin
      push_entry = make_trap(fetch_pc_reg, EXC_INST_ADDR_MISALIGNED);
    end else if (ibus_err_i) begin
      push_entry = make_trap(resp_pc_reg, EXC_INST_ACCESS_FAULT);
    end
  end

  morty_if_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_entry = head_bits;
  assign id_valid_o = !fifo_empty;

  always_comb begin
    id_pc_o          = '0;
    id_instruction_o = '0;
    id_exception_o   = '0;
    id_exc_data_o    = '0;
    id_trap_valid_o  = 1'b0;
    if (id_valid_o) begin
      id_pc_o          = head_entry.pc;
      id_instruction_o = head_entry.inst;
      id_exception_o   = head_entry.exc;
      id_exc_data_o    = head_entry.trap ? head_entry.pc : 32'h0;
      id_trap_valid_o  = head_entry.trap;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg        <= FETCH_RUN;
      fetch_pc_reg     <= RESET_ADDR;
      resp_pc_reg      <= RESET_ADDR;
      outstanding_reg  <= '0;
      discard_reg      <= '0;
      trap_pending_reg <= 1'b0;
    end else if (redirect_valid_i) begin
      // Everything still in flight belongs to the old stream.
      fetch_pc_reg     <= redirect_pc_i;
      resp_pc_reg      <= redirect_pc_i;
      outstanding_reg  <= outstanding_next;
      discard_reg      <= outstanding_next;
      state_reg        <= misaligned ? FETCH_HALT : FETCH_RUN;
      trap_pending_reg <= misaligned;
    end else begin
      outstanding_reg  <= outstanding_next;
      trap_pending_reg <= 1'b0;
      if (issue) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      if (ibus_rvalid_i && (discard_reg != '0)) begin
        discard_reg <= discard_reg - OW'(1);
      end
      if (accept_rsp) begin
        resp_pc_reg <= resp_pc_reg + 32'd4;
        if (ibus_err_i) begin
          state_reg   <= FETCH_HALT;
          discard_reg <= outstanding_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_morty_if_prefetch.sv
// Bench for morty_if_prefetch: behavioural bus slave, stream-level scoreboard of the
// expected ID sequence, directed sequences, a redirect table and a random phase.
module tb_morty_if_prefetch;
  import morty_pkg::*;

  localparam int MAXO = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = 32'h0;
  logic        ibus_err_i = 1'b0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_instruction_o;
  logic [3:0]  id_exception_o;
  logic [31:0] id_exc_data_o;
  logic        id_trap_valid_o;

  morty_if_prefetch #(
    .RESET_ADDR      (32'h0),
    .DEPTH           (4),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .ibus_req_o       (ibus_req_o),
    .ibus_addr_o      (ibus_addr_o),
    .ibus_gnt_i       (ibus_gnt_i),
    .ibus_rvalid_i    (ibus_rvalid_i),
    .ibus_rdata_i     (ibus_rdata_i),
    .ibus_err_i       (ibus_err_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_pc_o          (id_pc_o),
    .id_instruction_o (id_instruction_o),
    .id_exception_o   (id_exception_o),
    .id_exc_data_o    (id_exc_data_o),
    .id_trap_valid_o  (id_trap_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  bit          rnd = 1'b0;
  int          lat = 1;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;

  // Stream model: after a redirect to P the ID stream is P, P+4, ... up to the first trap.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_fetch = 32'h0;
  bit          m_active = 1'b1;
  bit          m_mis = 1'b0;

  int          grants = 0;
  int          pops = 0;
  bit          want_first = 1'b0;
  logic [31:0] first_pc = 32'h0;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_data = 32'h0;
  logic [3:0]  last_exc = 4'h0;
  logic        last_trap = 1'b0;

  typedef struct {
    logic [31:0] target;
    bit          err_en;
    logic [31:0] err_addr;
    int          exp_n;
    logic [31:0] exp_pc;
    logic        exp_trap;
    logic [3:0]  exp_exc;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    m_pc     = pc;
    m_fetch  = pc;
    m_active = 1'b1;
    m_mis    = (pc[1:0] != 2'b00);
  endtask

  task automatic check_pop();
    logic [31:0] ep, ei, ed;
    logic [3:0]  ee;
    logic        et;
    pops++;
    if (!m_active) begin
      chk("pop_after_trap", 128'(id_valid_o), 128'(0));
      return;
    end
    ep = m_pc;
    if (m_mis) begin
      ei = NOP_INSN; ee = 4'h0; et = 1'b1; ed = m_pc; m_active = 1'b0;
    end else if (err_en && m_pc == err_addr) begin
      ei = NOP_INSN; ee = 4'h1; et = 1'b1; ed = m_pc; m_active = 1'b0;
    end else begin
      ei = memf(m_pc); ee = 4'h0; et = 1'b0; ed = 32'h0; m_pc = m_pc + 32'd4;
    end
    chk("pop_entry",
        {id_pc_o, id_instruction_o, id_exception_o, id_exc_data_o, 3'b000, id_trap_valid_o},
        {ep, ei, ee, ed, 3'b000, et});
  endtask

  // One clock: drive the slave, observe at mid-cycle, advance to just after the edge.
  task automatic cycle();
    bit          do_gnt;
    bit          do_rv;
    logic [31:0] ra;
    pend_t       p;
    do_gnt = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    do_rv  = 1'b0;
    ra     = 32'h0;
    if (rst_ni && pend.size() > 0 && cyc >= pend[0].due)
      do_rv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (do_rv) ra = pend[0].addr;
    ibus_gnt_i    = do_gnt;
    ibus_rvalid_i = do_rv;
    ibus_rdata_i  = do_rv ? memf(ra) : 32'h0;
    ibus_err_i    = do_rv && err_en && (ra == err_addr);
    #1;
    if (rst_ni) begin
      if (m_mis && !redirect_valid_i) chk("no_req_when_misaligned", 128'(ibus_req_o), 128'(0));
      if (ibus_req_o && ibus_gnt_i) begin
        chk("outstanding_bound", 128'(pend.size() < MAXO), 128'(1));
        chk("fetch_addr", 128'(ibus_addr_o), 128'(m_fetch));
        m_fetch = m_fetch + 32'd4;
        grants++;
        p.addr = ibus_addr_o;
        p.due  = cyc + (rnd ? int'($urandom_range(1, 4)) : lat);
        pend.push_back(p);
      end
      if (id_valid_o && id_ready_i && !redirect_valid_i) begin
        if (want_first) begin
          first_pc   = id_pc_o;
          want_first = 1'b0;
        end
        last_pc   = id_pc_o;
        last_data = id_exc_data_o;
        last_exc  = id_exception_o;
        last_trap = id_trap_valid_o;
        check_pop();
      end
      if (do_rv) void'(pend.pop_front());
      if (redirect_valid_i) model_restart(redirect_pc_i);
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_ni = 1'b0;
    redirect_valid_i = 1'b0;
    id_ready_i = 1'b0;
    pend.delete();
    repeat (n) cycle();
    model_restart(32'h0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
    cycle();
    redirect_valid_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h0000_0100, 1'b0, 32'h0,        8, 32'h0000_011C, 1'b0, 4'h0, 32'h0};
    tbl[1] = '{32'h0000_0102, 1'b0, 32'h0,        1, 32'h0000_0102, 1'b1, 4'h0, 32'h0000_0102};
    tbl[2] = '{32'h0000_0200, 1'b1, 32'h208,      3, 32'h0000_0208, 1'b1, 4'h1, 32'h0000_0208};
    tbl[3] = '{32'h0000_0300, 1'b1, 32'h300,      1, 32'h0000_0300, 1'b1, 4'h1, 32'h0000_0300};
    tbl[4] = '{32'hFFFF_FFF8, 1'b0, 32'h0,        8, 32'h0000_0014, 1'b0, 4'h0, 32'h0};
    tbl[5] = '{32'h0000_0401, 1'b1, 32'h400,      1, 32'h0000_0401, 1'b1, 4'h0, 32'h0000_0401};
    tbl[6] = '{32'h0000_0500, 1'b1, 32'h51C,      8, 32'h0000_051C, 1'b1, 4'h1, 32'h0000_051C};

    // Reset state, then the first request after release.
    do_reset(2);
    chk("reset_req", 128'(ibus_req_o), 128'(0));
    chk("reset_valid", 128'(id_valid_o), 128'(0));
    chk("reset_payload",
        128'({id_pc_o, id_instruction_o, id_exception_o, id_exc_data_o, id_trap_valid_o}), 128'(0));
    rst_ni = 1'b1;
    id_ready_i = 1'b1;
    #1;
    chk("first_req", 128'(ibus_req_o), 128'(1));
    chk("first_addr", 128'(ibus_addr_o), 128'(32'h0));

    // Streaming: first entry two cycles after its grant, then no gaps.
    for (int c = 0; c < 14; c++) begin
      chk("stream_valid", 128'(id_valid_o), 128'(c >= 2));
      cycle();
    end

    // Stall: with ID blocked, exactly DEPTH fetches go out and the request drops.
    id_ready_i = 1'b0;
    redirect(32'h40);
    grants = 0;
    repeat (12) cycle();
    chk("stall_grants", 128'(grants), 128'(4));
    chk("stall_req_low", 128'(ibus_req_o), 128'(0));
    chk("stall_valid", 128'(id_valid_o), 128'(1));
    id_ready_i = 1'b1;
    pops = 0;
    repeat (12) cycle();
    chk("stall_resume_pc", 128'(last_pc), 128'(32'h40 + 32'(4 * (pops - 1))));

    // Redirect with two responses in flight.
    lat = 3;
    for (int i = 0; i < 20 && pend.size() != 2; i++) cycle();
    chk("two_outstanding", 128'(pend.size()), 128'(2));
    want_first = 1'b1;
    first_pc = 32'hDEAD_BEEF;
    redirect(32'h100);
    repeat (15) cycle();
    chk("redirect_first_pc", 128'(first_pc), 128'(32'h100));
    lat = 1;

    // Redirect table: collect up to 8 entries per target.
    for (int r = 0; r < 7; r++) begin
      err_en   = tbl[r].err_en;
      err_addr = tbl[r].err_addr;
      id_ready_i = 1'b1;
      pops = 0;
      redirect(tbl[r].target);
      for (int c = 0; c < 40; c++) begin
        id_ready_i = (pops < 8);
        cycle();
      end
      chk("tbl_count", 128'(pops), 128'(tbl[r].exp_n));
      chk("tbl_last", {last_pc, last_data, last_exc, 3'b000, last_trap},
          {tbl[r].exp_pc, tbl[r].exp_data, tbl[r].exp_exc, 3'b000, tbl[r].exp_trap});
    end

    // Random phase: random grant/latency/ready, random redirects, one mid-run reset.
    rnd = 1'b1;
    err_en = 1'b0;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      if (i == 1500) begin
        do_reset(2);
        rst_ni = 1'b1;
      end
      id_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        t = 32'($urandom_range(0, 1023)) << 2;
        err_en   = ($urandom_range(0, 2) == 0);
        err_addr = t + 32'(4 * $urandom_range(0, 5));
        if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
        redirect(t);
      end else begin
        cycle();
      end
    end
    chk("random_progress", 128'(pops > 50), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
